// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter and strobe sequencer for an asynchronous 16-bit SRAM.
// Each granted word runs through ACCESS (WAIT_CYCLES+1 cycles) and then HOLD, where the port is acked.
module sram_arbiter #(
    parameter int WAIT_CYCLES = 1,
    parameter int ADDR_WIDTH  = 18
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [15:0]           a_wdata,
    input  logic [1:0]            a_be,
    output logic                  a_ack,
    output logic [15:0]           a_rdata,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [15:0]           b_wdata,
    input  logic [1:0]            b_be,
    output logic                  b_ack,
    output logic [15:0]           b_rdata,
    output logic [ADDR_WIDTH-1:0] SRAM_ADDR,
    inout  wire  [15:0]           SRAM_DQ,
    output logic                  SRAM_CE_N,
    output logic                  SRAM_OE_N,
    output logic                  SRAM_WE_N,
    output logic                  SRAM_UB_N,
    output logic                  SRAM_LB_N
);

    typedef enum logic [1:0] {IDLE, ACCESS, HOLD} state_t;

    state_t                state, state_next;
    logic [3:0]            cnt, cnt_next;
    logic                  last_grant_b, last_grant_b_next;
    logic                  port_b, port_b_next;
    logic                  grant_a, grant_b;

    logic                  lat_we;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [15:0]           lat_wdata;
    logic [1:0]            lat_be;

    logic                  op_we;
    logic [ADDR_WIDTH-1:0] op_addr;
    logic [15:0]           op_wdata;
    logic [1:0]            op_be;

    logic                  ce_n_next, oe_n_next, we_n_next, ub_n_next, lb_n_next;
    logic [ADDR_WIDTH-1:0] addr_next;
    logic                  dq_oe, dq_oe_next;
    logic [15:0]           dq_out, dq_out_next;
    logic                  a_ack_next, b_ack_next;
    logic                  capture_a, capture_b;

    // Arbitration, sequencing and the next value of every registered pin.
    // Pins are computed from state_next so they change on the same edge as the state.
    always_comb begin
        state_next        = state;
        cnt_next          = cnt;
        last_grant_b_next = last_grant_b;
        port_b_next       = port_b;
        grant_a           = 1'b0;
        grant_b           = 1'b0;

        case (state)
            IDLE: begin
                if (a_req && (!b_req || last_grant_b)) begin
                    grant_a = 1'b1;
                end else if (b_req) begin
                    grant_b = 1'b1;
                end
                if (grant_a || grant_b) begin
                    state_next        = ACCESS;
                    cnt_next          = 4'(WAIT_CYCLES);
                    last_grant_b_next = grant_b;
                    port_b_next       = grant_b;
                end
            end
            ACCESS: begin
                if (cnt == 4'd0) begin
                    state_next = HOLD;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            HOLD:    state_next = IDLE;
            default: state_next = IDLE;
        endcase

        // On the grant edge the latches are not loaded yet, so take fields from the winner.
        if (grant_a) begin
            op_we = a_we; op_addr = a_addr; op_wdata = a_wdata; op_be = a_be;
        end else if (grant_b) begin
            op_we = b_we; op_addr = b_addr; op_wdata = b_wdata; op_be = b_be;
        end else begin
            op_we = lat_we; op_addr = lat_addr; op_wdata = lat_wdata; op_be = lat_be;
        end

        ce_n_next   = 1'b1;
        oe_n_next   = 1'b1;
        we_n_next   = 1'b1;
        ub_n_next   = 1'b1;
        lb_n_next   = 1'b1;
        addr_next   = SRAM_ADDR;
        dq_oe_next  = 1'b0;
        dq_out_next = dq_out;
        a_ack_next  = 1'b0;
        b_ack_next  = 1'b0;

        if (state_next == ACCESS || state_next == HOLD) begin
            ce_n_next   = 1'b0;
            addr_next   = op_addr;
            ub_n_next   = ~op_be[1];
            lb_n_next   = ~op_be[0];
            dq_oe_next  = op_we;
            dq_out_next = op_wdata;
        end
        if (state_next == ACCESS) begin
            oe_n_next = op_we;
            we_n_next = ~op_we;
        end
        if (state_next == HOLD) begin
            a_ack_next = ~port_b_next;
            b_ack_next = port_b_next;
        end

        capture_a = (state == ACCESS) && (cnt == 4'd0) && !lat_we && !port_b;
        capture_b = (state == ACCESS) && (cnt == 4'd0) && !lat_we && port_b;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            last_grant_b <= 1'b1;
            port_b       <= 1'b0;
            lat_we       <= 1'b0;
            lat_addr     <= '0;
            lat_wdata    <= 16'h0000;
            lat_be       <= 2'b00;
            SRAM_CE_N    <= 1'b1;
            SRAM_OE_N    <= 1'b1;
            SRAM_WE_N    <= 1'b1;
            SRAM_UB_N    <= 1'b1;
            SRAM_LB_N    <= 1'b1;
            SRAM_ADDR    <= '0;
            dq_oe        <= 1'b0;
            dq_out       <= 16'h0000;
            a_ack        <= 1'b0;
            b_ack        <= 1'b0;
            a_rdata      <= 16'h0000;
            b_rdata      <= 16'h0000;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            last_grant_b <= last_grant_b_next;
            port_b       <= port_b_next;
            if (grant_a || grant_b) begin
                lat_we    <= op_we;
                lat_addr  <= op_addr;
                lat_wdata <= op_wdata;
                lat_be    <= op_be;
            end
            SRAM_CE_N <= ce_n_next;
            SRAM_OE_N <= oe_n_next;
            SRAM_WE_N <= we_n_next;
            SRAM_UB_N <= ub_n_next;
            SRAM_LB_N <= lb_n_next;
            SRAM_ADDR <= addr_next;
            dq_oe     <= dq_oe_next;
            dq_out    <= dq_out_next;
            a_ack     <= a_ack_next;
            b_ack     <= b_ack_next;
            if (capture_a) a_rdata <= SRAM_DQ;
            if (capture_b) b_rdata <= SRAM_DQ;
        end
    end

    // Gating with reset releases the bus in the very cycle reset is sampled.
    assign SRAM_DQ = (dq_oe && !reset) ? dq_out : 16'bz;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: a WAIT_CYCLES=1 instance on a behavioural SRAM,
// plus three read-only instances (WAIT_CYCLES 0, 3, 15) for the latency sweep.
module tb_sram_arbiter;

    localparam int W = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_req, a_we, b_req, b_we;
    logic [17:0] a_addr, b_addr;
    logic [15:0] a_wdata, b_wdata;
    logic [1:0]  a_be, b_be;
    wire         a_ack, b_ack;
    wire  [15:0] a_rdata, b_rdata;
    wire  [17:0] sram_addr;
    wire  [15:0] sram_dq;
    wire         ce_n, oe_n, we_n, ub_n, lb_n;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_arbiter #(.WAIT_CYCLES(W), .ADDR_WIDTH(18)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_be(a_be),
        .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_be(b_be),
        .b_ack(b_ack), .b_rdata(b_rdata),
        .SRAM_ADDR(sram_addr), .SRAM_DQ(sram_dq), .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n),
        .SRAM_WE_N(we_n), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n)
    );

    // Behavioural SRAM: unwritten words read as 0xFFFF, writes honour byte lanes.
    logic [15:0] mem     [0:262143];
    logic        written [0:262143];
    logic [15:0] mem_word;

    assign mem_word = written[sram_addr] ? mem[sram_addr] : 16'hFFFF;
    assign sram_dq  = (!ce_n && !oe_n && we_n) ? mem_word : 16'bz;

    always @(posedge clk) begin
        if (!ce_n && !we_n) begin
            mem[sram_addr]     <= {(!ub_n ? sram_dq[15:8] : mem_word[15:8]),
                                   (!lb_n ? sram_dq[7:0]  : mem_word[7:0])};
            written[sram_addr] <= 1'b1;
        end
    end

    // Sweep instances share inputs apart from per-instance requests.
    logic [2:0]  s_req;
    logic [17:0] s_addr;
    wire  [2:0]  s_ack, s_b_ack, s_ce_n, s_oe_n, s_we_n, s_ub_n, s_lb_n;
    wire  [47:0] s_rdata, s_b_rdata;
    wire  [53:0] s_sram_addr;
    wire  [15:0] s_dq0, s_dq1, s_dq2;

    assign s_dq0 = !s_oe_n[0] ? 16'h5A00 : 16'bz;
    assign s_dq1 = !s_oe_n[1] ? 16'h5A03 : 16'bz;
    assign s_dq2 = !s_oe_n[2] ? 16'h5A0F : 16'bz;

    sram_arbiter #(.WAIT_CYCLES(0), .ADDR_WIDTH(18)) sweep0 (
        .clk(clk), .reset(reset),
        .a_req(s_req[0]), .a_we(1'b0), .a_addr(s_addr), .a_wdata(16'h0000), .a_be(2'b11),
        .a_ack(s_ack[0]), .a_rdata(s_rdata[15:0]),
        .b_req(1'b0), .b_we(1'b0), .b_addr(18'h0), .b_wdata(16'h0000), .b_be(2'b00),
        .b_ack(s_b_ack[0]), .b_rdata(s_b_rdata[15:0]),
        .SRAM_ADDR(s_sram_addr[17:0]), .SRAM_DQ(s_dq0), .SRAM_CE_N(s_ce_n[0]),
        .SRAM_OE_N(s_oe_n[0]), .SRAM_WE_N(s_we_n[0]), .SRAM_UB_N(s_ub_n[0]), .SRAM_LB_N(s_lb_n[0])
    );

    sram_arbiter #(.WAIT_CYCLES(3), .ADDR_WIDTH(18)) sweep3 (
        .clk(clk), .reset(reset),
        .a_req(s_req[1]), .a_we(1'b0), .a_addr(s_addr), .a_wdata(16'h0000), .a_be(2'b11),
        .a_ack(s_ack[1]), .a_rdata(s_rdata[31:16]),
        .b_req(1'b0), .b_we(1'b0), .b_addr(18'h0), .b_wdata(16'h0000), .b_be(2'b00),
        .b_ack(s_b_ack[1]), .b_rdata(s_b_rdata[31:16]),
        .SRAM_ADDR(s_sram_addr[35:18]), .SRAM_DQ(s_dq1), .SRAM_CE_N(s_ce_n[1]),
        .SRAM_OE_N(s_oe_n[1]), .SRAM_WE_N(s_we_n[1]), .SRAM_UB_N(s_ub_n[1]), .SRAM_LB_N(s_lb_n[1])
    );

    sram_arbiter #(.WAIT_CYCLES(15), .ADDR_WIDTH(18)) sweep15 (
        .clk(clk), .reset(reset),
        .a_req(s_req[2]), .a_we(1'b0), .a_addr(s_addr), .a_wdata(16'h0000), .a_be(2'b11),
        .a_ack(s_ack[2]), .a_rdata(s_rdata[47:32]),
        .b_req(1'b0), .b_we(1'b0), .b_addr(18'h0), .b_wdata(16'h0000), .b_be(2'b00),
        .b_ack(s_b_ack[2]), .b_rdata(s_b_rdata[47:32]),
        .SRAM_ADDR(s_sram_addr[53:36]), .SRAM_DQ(s_dq2), .SRAM_CE_N(s_ce_n[2]),
        .SRAM_OE_N(s_oe_n[2]), .SRAM_WE_N(s_we_n[2]), .SRAM_UB_N(s_ub_n[2]), .SRAM_LB_N(s_lb_n[2])
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // One transfer on one port, entered at a negedge of an IDLE cycle; returns at the next IDLE negedge.
    task automatic applyStimulus(input logic port_b, input logic we, input logic [17:0] addr,
                                 input logic [15:0] wdata, input logic [1:0] be,
                                 output int ack_cycle, output int we_low,
                                 output logic [1:0] lanes, output logic [15:0] dq1,
                                 output logic [17:0] addr1, output logic [15:0] rdata);
        if (port_b) begin
            b_we = we; b_addr = addr; b_wdata = wdata; b_be = be; b_req = 1'b1;
        end else begin
            a_we = we; a_addr = addr; a_wdata = wdata; a_be = be; a_req = 1'b1;
        end
        ack_cycle = -1; we_low = 0; lanes = 2'b11; dq1 = 16'h0; addr1 = 18'h0; rdata = 16'h0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (!we_n) we_low++;
            if (k == 1) begin
                lanes = {ub_n, lb_n};
                dq1   = sram_dq;
                addr1 = sram_addr;
            end
            if (port_b ? b_ack : a_ack) begin
                ack_cycle = k;
                rdata     = port_b ? b_rdata : a_rdata;
                break;
            end
        end
        a_req = 1'b0;
        b_req = 1'b0;
        @(negedge clk);
    endtask

    // Both ports hold requests for n writes each; acks must alternate A, B at fixed spacing.
    task automatic runBoth(input int n);
        int na, nb, idx;
        na = n; nb = n; idx = 0;
        a_we = 1'b1; a_addr = 18'h00400; a_wdata = 16'hAAAA; a_be = 2'b11;
        b_we = 1'b1; b_addr = 18'h00500; b_wdata = 16'hBBBB; b_be = 2'b11;
        a_req = 1'b1; b_req = 1'b1;
        for (int k = 1; k <= 2 * n * (W + 3) + 20; k++) begin
            @(negedge clk);
            if (a_ack || b_ack) begin
                checkOutput("one_ack_only", a_ack & b_ack, 1'b0);
                checkOutput("grant_order_b", b_ack, 64'(idx % 2));
                checkOutput("ack_cycle", 64'(k), 64'(2 + W + idx * (W + 3)));
                idx++;
                if (a_ack) begin
                    na--;
                    if (na == 0) a_req = 1'b0;
                end
                if (b_ack) begin
                    nb--;
                    if (nb == 0) b_req = 1'b0;
                end
                if (na <= 0 && nb <= 0) break;
            end
        end
        checkOutput("ack_total", 64'(idx), 64'(2 * n));
        a_req = 1'b0;
        b_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          lat, wlow;
        logic [1:0]  lanes;
        logic [15:0] dq1, rd;
        logic [17:0] ad1;
        int          sw [3];
        int          s_ack_k [3];
        int          s_ce_cnt [3];
        logic [15:0] s_rd [3];
        logic        seen;

        reset = 1'b1;
        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0; a_be = 2'b00;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0; b_be = 2'b00;
        s_req = 3'b000; s_addr = '0;
        repeat (3) @(negedge clk);

        checkOutput("reset_ctrl", {ce_n, oe_n, we_n, ub_n, lb_n}, 5'b11111);
        checkOutput("reset_addr", sram_addr, 18'h0);
        checkOutput("reset_dq_z", (sram_dq === 16'bz), 1'b1);
        checkOutput("reset_acks", {a_ack, b_ack}, 2'b00);
        checkOutput("reset_rdata", {a_rdata, b_rdata}, 32'h0);
        reset = 1'b0;

        $display("[TB] single write then read");
        applyStimulus(1'b0, 1'b1, 18'h00123, 16'hBEEF, 2'b11, lat, wlow, lanes, dq1, ad1, rd);
        checkOutput("wr_ack_cycle", 64'(lat), 64'(W + 2));
        checkOutput("wr_we_low", 64'(wlow), 64'(W + 1));
        checkOutput("wr_dq", dq1, 16'hBEEF);
        checkOutput("wr_addr", ad1, 18'h00123);
        applyStimulus(1'b0, 1'b0, 18'h00123, 16'h0000, 2'b11, lat, wlow, lanes, dq1, ad1, rd);
        checkOutput("rd_ack_cycle", 64'(lat), 64'(W + 2));
        checkOutput("rd_we_low", 64'(wlow), 0);
        checkOutput("rd_data", rd, 16'hBEEF);

        $display("[TB] byte lanes");
        applyStimulus(1'b0, 1'b1, 18'h00200, 16'h1234, 2'b10, lat, wlow, lanes, dq1, ad1, rd);
        checkOutput("be10_lanes", lanes, 2'b01);
        checkOutput("be10_ack_cycle", 64'(lat), 64'(W + 2));
        checkOutput("rdata_kept_after_write", a_rdata, 16'hBEEF);
        checkOutput("b_rdata_untouched", b_rdata, 16'h0000);
        applyStimulus(1'b0, 1'b0, 18'h00200, 16'h0000, 2'b11, lat, wlow, lanes, dq1, ad1, rd);
        checkOutput("be10_readback", rd, 16'h12FF);

        $display("[TB] wait-count sweep");
        sw = '{0, 3, 15};
        s_ack_k = '{-1, -1, -1};
        s_ce_cnt = '{0, 0, 0};
        s_rd = '{16'h0, 16'h0, 16'h0};
        seen = 1'b0;
        s_addr = 18'h30F0F;
        s_req = 3'b111;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            seen = seen | (|s_b_ack);
            for (int i = 0; i < 3; i++) begin
                if (!s_ce_n[i]) s_ce_cnt[i]++;
                if (s_ack[i] && s_ack_k[i] < 0) begin
                    s_ack_k[i] = k;
                    s_rd[i]    = s_rdata[i*16 +: 16];
                    checkOutput("sweep_hold_pins",
                                {s_sram_addr[i*18 +: 18], s_we_n[i], s_ub_n[i], s_lb_n[i]},
                                {s_addr, 3'b100});
                    s_req[i] = 1'b0;
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            checkOutput("sweep_ack_cycle", 64'(s_ack_k[i]), 64'(sw[i] + 2));
            checkOutput("sweep_ce_low", 64'(s_ce_cnt[i]), 64'(sw[i] + 2));
            checkOutput("sweep_rdata", s_rd[i], 16'h5A00 | 16'(sw[i]));
        end
        checkOutput("sweep_b_idle", {seen, s_b_rdata}, 49'h0);

        $display("[TB] simultaneous requests after reset");
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        runBoth(3);

        $display("[TB] reset during B write");
        b_we = 1'b1; b_addr = 18'h00300; b_wdata = 16'hCAFE; b_be = 2'b11; b_req = 1'b1;
        @(negedge clk);
        checkOutput("b_access_we", we_n, 1'b0);
        reset = 1'b1;
        b_req = 1'b0;
        @(negedge clk);
        checkOutput("abort_ctrl", {ce_n, oe_n, we_n, ub_n, lb_n}, 5'b11111);
        checkOutput("abort_dq_z", (sram_dq === 16'bz), 1'b1);
        seen = b_ack;
        @(negedge clk);
        seen = seen | b_ack;
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen = seen | b_ack;
        end
        checkOutput("abort_no_b_ack", seen, 1'b0);
        runBoth(1);

        $display("[TB] late request from B");
        a_we = 1'b0; a_addr = 18'h00123; a_be = 2'b11; a_req = 1'b1;
        b_we = 1'b0; b_addr = 18'h00200; b_be = 2'b11;
        seen = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (k == 1) b_req = 1'b1;
            if (!ce_n) checkOutput("late_addr", sram_addr, (k <= W + 2) ? a_addr : b_addr);
            if (a_ack) begin
                checkOutput("late_a_ack_cycle", 64'(k), 64'(W + 2));
                checkOutput("late_a_rdata", a_rdata, 16'hBEEF);
                a_req = 1'b0;
            end
            if (b_ack) begin
                checkOutput("late_b_ack_cycle", 64'(k), 64'(2 * W + 5));
                checkOutput("late_b_rdata", b_rdata, 16'h12FF);
                b_req = 1'b0;
                seen  = 1'b1;
                break;
            end
        end
        checkOutput("late_b_served", seen, 1'b1);
        a_req = 1'b0;
        b_req = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
